align_add: RTL and testbench
============================

Name: align_add

Overview:
- Operand alignment and mantissa add/subtract stage of the MAC5 datapath; sits directly upstream of the normalisation stage.
- Takes two small floats: the product operand A and the accumulator operand B.
- Selects the larger-exponent operand, right-shifts the smaller mantissa, and adds or subtracts.
- Produces the raw 3-bit sum, sign-selection bits and pre-normalisation exponent that the normaliser consumes.

Parameters:
- EW, 3, exponent width (unsigned, no bias handling here).
- MW, 2, mantissa width including explicit leading one; a value of all zeros means the operand is zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid this cycle
- hold  input  1  pipeline stall; all registers keep their value
- a_s  input  1  sign of A
- a_e  input  EW  exponent of A
- a_m  input  MW  mantissa of A
- b_s  input  1  sign of B
- b_e  input  EW  exponent of B
- b_m  input  MW  mantissa of B
- out_valid  output  1  outputs below are valid
- mxy1  output  MW+1  raw aligned sum/difference, two's complement when subtracting
- s  output  1  1 = A is the base (larger) operand, 0 = B
- s1  output  1  sign of A, registered
- s2  output  1  sign of B, registered
- s3  output  1  effective subtract (a_s ^ b_s)
- ex  output  EW  pre-normalisation exponent
- ovf  output  1  exponent saturated
- zero  output  1  both operands zero

Behaviour:
- Clocking and reset:
  - One clock (clk); reset rst is synchronous and active-high.
  - rst has priority over hold. On reset, all stage registers and outputs go to 0 (out_valid=0, mxy1=0, s=s1=s2=s3=0, ex=0, ovf=0, zero=0).
- Pipeline:
  - Two register stages; latency 2 cycles from in_valid to out_valid. Throughput is one operand pair per cycle.
  - No backpressure: the downstream stage samples every clock.
  - hold=1 freezes both stages, including the valid bits. Inputs presented during hold are dropped.
  - When hold=0 and in_valid=0, a bubble (valid=0) is inserted. Data registers may update on a bubble; out_valid is the only qualifier.
- Stage 1 (compare/swap), registered:
  - Effective exponent: eA = (a_m==0) ? 0 : a_e; eB likewise.
  - s = (a_m!=0) && (b_m==0 || eA >= eB). On an exponent tie, A is the base.
  - Register: e_big, d = e_big - e_small (EW bits), M_big, M_small, s, s1=a_s, s2=b_s, s3=a_s^b_s, zero=(a_m==0 && b_m==0).
- Stage 2 (shift/add), registered:
  - M_sh = M_small >> d. Truncate with no sticky bit; M_sh=0 when d >= MW.
  - s3=0: mxy1 = {0,M_big} + {0,M_sh}. The carry lands in mxy1[MW].
  - s3=1: mxy1 = {0,M_big} - {0,M_sh}, mod 2^(MW+1). mxy1[MW]=1 means negative; the normaliser negates the value and flips the sign.
  - ex = e_big + 1, because the normaliser takes mxy1[MW:1] as the mantissa.
  - If e_big == 2^EW-1: ex = 2^EW-1 and ovf=1; mxy1 is computed unchanged. Otherwise ovf=0.
  - If zero=1: mxy1=0, ex=0, s=0, ovf=0.
- s1, s2, s3 and s pass through stage 2 unchanged.
- Simultaneous events: rst with hold → reset wins. hold with in_valid → the input is lost, and the caller must re-present it.

Test Plan:
- Reset with hold: assert rst for 2 cycles while hold=1 → every output is 0 on the next edge and out_valid=0.
- Equal-exponent add: A=(0,3,10), B=(0,3,10), in_valid for 1 cycle → after 2 cycles out_valid=1, s=1, s3=0, mxy1=100, ex=4, ovf=0, zero=0.
- B larger, fully shifted out: A=(0,2,11), B=(1,4,10) → s=0, s1=0, s2=1, s3=1, mxy1=010, ex=5.
- Negative difference: A=(0,3,10), B=(1,3,11) → s=1, s3=1, mxy1=111, ex=4; the normaliser then yields sr=1.
- Overflow and zero cases:
  - A=(0,7,11), B=(0,6,10) → mxy1=100, ex=7, ovf=1.
  - A=(0,7,00), B=(1,2,10) → s=0, mxy1=010, ex=3.
  - A=(0,5,00), B=(0,1,00) → zero=1, mxy1=000, ex=0.
- Stall and back-to-back: valid pairs at cycles 0,1,2, hold=1 at cycle 2 only → outputs freeze for one cycle. The pair from cycle 2 never appears, and out_valid shows the cycle-0 and cycle-1 results only, in order.

Source files
------------

// File: rtl/align_add_if.sv
// -----------------------------------------------------------------------------
// align_add_if
//   Operand/result bundle for the align_add stage of the MAC5 datapath.
//
//   Upstream side (driven into align_add):
//     in_valid          operands valid this cycle
//     hold              pipeline stall, every stage register keeps its value
//     a_s / a_e / a_m   sign, exponent, mantissa of the product operand A
//     b_s / b_e / b_m   sign, exponent, mantissa of the accumulator operand B
//
//   Downstream side (driven by align_add, consumed by the normaliser):
//     out_valid         the result fields below are meaningful
//     mxy1              raw aligned sum/difference, MW+1 bits
//     s                 1 = A was the base (larger) operand, 0 = B
//     s1 / s2           registered signs of A and B
//     s3                effective subtract (a_s ^ b_s)
//     ex                pre-normalisation exponent
//     ovf               exponent saturated
//     zero              both operands were zero
//
//   master : the side that supplies operands and receives results
//   slave  : the align_add stage itself
// -----------------------------------------------------------------------------
interface align_add_if #(
   parameter int EW = 3,
   parameter int MW = 2
);

   logic          in_valid;
   logic          hold;
   logic          a_s;
   logic [EW-1:0] a_e;
   logic [MW-1:0] a_m;
   logic          b_s;
   logic [EW-1:0] b_e;
   logic [MW-1:0] b_m;

   logic          out_valid;
   logic [MW:0]   mxy1;
   logic          s;
   logic          s1;
   logic          s2;
   logic          s3;
   logic [EW-1:0] ex;
   logic          ovf;
   logic          zero;

   modport master (
      output in_valid, hold, a_s, a_e, a_m, b_s, b_e, b_m,
      input  out_valid, mxy1, s, s1, s2, s3, ex, ovf, zero
   );

   modport slave (
      input  in_valid, hold, a_s, a_e, a_m, b_s, b_e, b_m,
      output out_valid, mxy1, s, s1, s2, s3, ex, ovf, zero
   );

endinterface : align_add_if

// File: rtl/align_add.sv
// -----------------------------------------------------------------------------
// align_add
//   Operand alignment and mantissa add/subtract stage of the MAC5 datapath.
//   Picks the operand with the larger effective exponent as the base, shifts
//   the other mantissa right by the exponent difference (truncating, no
//   sticky bit) and adds or subtracts depending on the sign combination.
//   The raw MW+1 bit result, the sign-selection bits and the
//   pre-normalisation exponent go straight to the normaliser.
//
//   Pipeline: two register stages, latency 2, one operand pair per cycle.
//     stage 1 : compare / swap
//     stage 2 : shift / add, exponent increment and saturation
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset, takes priority over hold
//     bus   align_add_if slave modport (operands in, results out, hold)
// -----------------------------------------------------------------------------
module align_add #(
   parameter int EW = 3,
   parameter int MW = 2
) (
   input  logic        clk,
   input  logic        rst,
   align_add_if.slave  bus
);

   // Largest representable exponent; reaching it saturates ex and flags ovf.
   localparam logic [EW-1:0] EMAX = {EW{1'b1}};
   // Shift distances at or beyond the mantissa width push everything out.
   localparam logic [EW-1:0] MW_E = EW'(MW);

   // Compare/swap result: everything stage 2 needs to align and combine.
   typedef struct packed {
      logic          valid;
      logic [EW-1:0] e_big;    // exponent of the base operand
      logic [EW-1:0] d;        // e_big - e_small, never negative
      logic [MW-1:0] m_big;    // base mantissa
      logic [MW-1:0] m_small;  // mantissa to be shifted right
      logic          s;        // 1 = A is the base
      logic          s1;
      logic          s2;
      logic          s3;
      logic          zero;
   } st1_t;

   // Shift/add result as presented to the normaliser.
   typedef struct packed {
      logic          valid;
      logic [MW:0]   mxy1;
      logic          s;
      logic          s1;
      logic          s2;
      logic          s3;
      logic [EW-1:0] ex;
      logic          ovf;
      logic          zero;
   } st2_t;

   st1_t st1_d, st1_q;
   st2_t st2_d, st2_q;

   // ---------------------------------------------------------------------------
   // Stage 1: compare / swap
   // ---------------------------------------------------------------------------
   logic [EW-1:0] ea;
   logic [EW-1:0] eb;
   logic          a_base;

   always_comb begin
      // NOTE: every signal written here gets a value before any condition so
      // no path leaves it unassigned and no latch is inferred.
      st1_d  = '0;
      ea     = '0;
      eb     = '0;
      a_base = 1'b0;

      // A zero mantissa is a zero operand; its exponent must not win the
      // comparison, so it is treated as 0.
      ea = (bus.a_m == '0) ? '0 : bus.a_e;
      eb = (bus.b_m == '0) ? '0 : bus.b_e;

      // A is the base unless it is zero, or B is non-zero with a strictly
      // larger exponent. Ties go to A.
      a_base = (bus.a_m != '0) && ((bus.b_m == '0) || (ea >= eb));

      st1_d.valid   = bus.in_valid;
      st1_d.s       = a_base;
      st1_d.e_big   = a_base ? ea : eb;
      st1_d.d       = a_base ? (ea - eb) : (eb - ea);
      st1_d.m_big   = a_base ? bus.a_m : bus.b_m;
      st1_d.m_small = a_base ? bus.b_m : bus.a_m;
      st1_d.s1      = bus.a_s;
      st1_d.s2      = bus.b_s;
      st1_d.s3      = bus.a_s ^ bus.b_s;
      st1_d.zero    = (bus.a_m == '0) && (bus.b_m == '0);
   end

   // ---------------------------------------------------------------------------
   // Stage 2: shift / add
   // ---------------------------------------------------------------------------
   logic [MW-1:0] m_sh;
   logic [MW:0]   sum_add;
   logic [MW:0]   sum_sub;

   always_comb begin
      st2_d   = '0;
      m_sh    = '0;
      sum_add = '0;
      sum_sub = '0;

      // Plain truncating shift; the explicit range check keeps the intent
      // obvious rather than relying on shift-past-width semantics.
      m_sh = (st1_q.d >= MW_E) ? '0 : (st1_q.m_small >> st1_q.d);

      sum_add = {1'b0, st1_q.m_big} + {1'b0, m_sh};
      // Wraps modulo 2^(MW+1); a set MSB tells the normaliser the difference
      // went negative and must be negated with the sign flipped.
      sum_sub = {1'b0, st1_q.m_big} - {1'b0, m_sh};

      st2_d.valid = st1_q.valid;
      st2_d.mxy1  = st1_q.s3 ? sum_sub : sum_add;
      st2_d.s     = st1_q.s;
      st2_d.s1    = st1_q.s1;
      st2_d.s2    = st1_q.s2;
      st2_d.s3    = st1_q.s3;
      st2_d.zero  = st1_q.zero;

      // The normaliser takes mxy1[MW:1] as its mantissa, which is a factor
      // of two down, so the exponent is pre-incremented here. At the top
      // exponent it cannot go further and saturates instead.
      if (st1_q.e_big == EMAX) begin
         st2_d.ex  = EMAX;
         st2_d.ovf = 1'b1;
      end else begin
         st2_d.ex  = st1_q.e_big + EW'(1);
         st2_d.ovf = 1'b0;
      end

      // Both operands zero: force a clean zero result.
      if (st1_q.zero) begin
         st2_d.mxy1 = '0;
         st2_d.ex   = '0;
         st2_d.s    = 1'b0;
         st2_d.ovf  = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage registers
   // ---------------------------------------------------------------------------
   // NOTE: non-blocking assignments so both stages sample the values from
   // before the edge; blocking here would let stage 1 race into stage 2.
   always_ff @(posedge clk) begin
      // NOTE: reset is checked first so it wins over hold; both stages
      // clear together so no stale valid bit survives a reset.
      if (rst) begin
         st1_q <= '0;
         st2_q <= '0;
      end else if (!bus.hold) begin
         st1_q <= st1_d;
         st2_q <= st2_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs come straight from the stage-2 register.
   // ---------------------------------------------------------------------------
   assign bus.out_valid = st2_q.valid;
   assign bus.mxy1      = st2_q.mxy1;
   assign bus.s         = st2_q.s;
   assign bus.s1        = st2_q.s1;
   assign bus.s2        = st2_q.s2;
   assign bus.s3        = st2_q.s3;
   assign bus.ex        = st2_q.ex;
   assign bus.ovf       = st2_q.ovf;
   assign bus.zero      = st2_q.zero;

endmodule : align_add

// File: tb/tb_align_add.sv
// -----------------------------------------------------------------------------
// tb_align_add
//   Self-checking bench for align_add. A cycle-level reference model holds
//   two result slots that advance when hold is low and clear on reset; each
//   result is computed from the operand values with integer arithmetic.
//   Directed steps reproduce the intended use cases with hand-derived
//   constants, followed by a randomized phase with hold and reset activity.
// -----------------------------------------------------------------------------
module tb_align_add;

   localparam int EW = 3;
   localparam int MW = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   align_add_if #(.EW(EW), .MW(MW)) bus ();

   align_add #(.EW(EW), .MW(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      bit valid;
      int mxy1;
      int s;
      int s1;
      int s2;
      int s3;
      int ex;
      int ovf;
      int zero;
   } exp_t;

   exp_t pipe [2];
   int   total = 0;
   int   bad   = 0;

   // Expected result of one operand pair, derived from the values directly.
   function automatic exp_t model(int as, int ae, int am, int bs, int be, int bm);
      exp_t r;
      int   ea, eb, e_big, e_small, m_big, m_small, aligned, raw;
      int   top  = (1 << EW) - 1;
      int   modv = 1 << (MW + 1);
      r.valid = 1'b1;
      r.s1    = as;
      r.s2    = bs;
      r.s3    = as ^ bs;
      if (am == 0 && bm == 0) begin
         r.zero = 1; r.mxy1 = 0; r.ex = 0; r.s = 0; r.ovf = 0;
         return r;
      end
      r.zero = 0;
      ea = (am == 0) ? 0 : ae;
      eb = (bm == 0) ? 0 : be;
      if (am != 0 && (bm == 0 || ea >= eb)) begin
         r.s = 1; e_big = ea; e_small = eb; m_big = am; m_small = bm;
      end else begin
         r.s = 0; e_big = eb; e_small = ea; m_big = bm; m_small = am;
      end
      // Value of the smaller operand expressed in units of the base exponent.
      aligned = m_small / (1 << (e_big - e_small));
      raw     = r.s3 ? (m_big - aligned) : (m_big + aligned);
      r.mxy1  = ((raw % modv) + modv) % modv;
      r.ovf   = (e_big == top) ? 1 : 0;
      r.ex    = (e_big == top) ? top : e_big + 1;
      return r;
   endfunction

   task automatic cmp(string tag, logic [31:0] obs, logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge, then
   // compare the DUT outputs 1 time unit later.
   task automatic tick();
      exp_t bubble;
      bubble = '{default: 0};
      @(posedge clk);
      if (rst) begin
         pipe[0] = bubble;
         pipe[1] = bubble;
      end else if (!bus.hold) begin
         pipe[1] = pipe[0];
         pipe[0] = bus.in_valid ?
                   model(int'(bus.a_s), int'(bus.a_e), int'(bus.a_m),
                         int'(bus.b_s), int'(bus.b_e), int'(bus.b_m)) : bubble;
      end
      #1;
      cmp("model.out_valid", 32'(bus.out_valid), 32'(pipe[1].valid));
      if (pipe[1].valid) begin
         cmp("model.mxy1", 32'(bus.mxy1), pipe[1].mxy1);
         cmp("model.s",    32'(bus.s),    pipe[1].s);
         cmp("model.s1",   32'(bus.s1),   pipe[1].s1);
         cmp("model.s2",   32'(bus.s2),   pipe[1].s2);
         cmp("model.s3",   32'(bus.s3),   pipe[1].s3);
         cmp("model.ex",   32'(bus.ex),   pipe[1].ex);
         cmp("model.ovf",  32'(bus.ovf),  pipe[1].ovf);
         cmp("model.zero", 32'(bus.zero), pipe[1].zero);
      end
   endtask

   task automatic set_ops(int as, int ae, int am, int bs, int be, int bm);
      bus.a_s = 1'(as); bus.a_e = EW'(ae); bus.a_m = MW'(am);
      bus.b_s = 1'(bs); bus.b_e = EW'(be); bus.b_m = MW'(bm);
   endtask

   task automatic expect_out(string tag, int v, int mxy1, int s, int s1, int s2,
                             int s3, int ex, int ovf, int zero);
      cmp({tag, ".out_valid"}, 32'(bus.out_valid), v);
      cmp({tag, ".mxy1"},      32'(bus.mxy1),      mxy1);
      cmp({tag, ".s"},         32'(bus.s),         s);
      cmp({tag, ".s1"},        32'(bus.s1),        s1);
      cmp({tag, ".s2"},        32'(bus.s2),        s2);
      cmp({tag, ".s3"},        32'(bus.s3),        s3);
      cmp({tag, ".ex"},        32'(bus.ex),        ex);
      cmp({tag, ".ovf"},       32'(bus.ovf),       ovf);
      cmp({tag, ".zero"},      32'(bus.zero),      zero);
   endtask

   // Present one pair for a single cycle and return with its result on the
   // outputs (two edges later).
   task automatic present(int as, int ae, int am, int bs, int be, int bm);
      set_ops(as, ae, am, bs, be, bm);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
   endtask

   initial begin
      pipe[0] = '{default: 0};
      pipe[1] = '{default: 0};

      // Reset while stalled, with junk operands marked valid.
      rst          = 1'b1;
      bus.hold     = 1'b1;
      bus.in_valid = 1'b1;
      set_ops(1, 7, 3, 1, 6, 2);
      tick();
      expect_out("rst_hold_1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      expect_out("rst_hold_2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst          = 1'b0;
      bus.hold     = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      tick();

      // Equal exponents, add: 10 + 10 = 100, ex = 3+1.
      present(0, 3, 2, 0, 3, 2);
      expect_out("eq_add", 1, 4, 1, 0, 0, 0, 4, 0, 0);
      tick();

      // B larger by 2, A shifted out entirely.
      present(0, 2, 3, 1, 4, 2);
      expect_out("b_big_shift_out", 1, 2, 0, 0, 1, 1, 5, 0, 0);
      tick();

      // Tie goes to A, difference negative: 10 - 11 = 111.
      present(0, 3, 2, 1, 3, 3);
      expect_out("neg_diff", 1, 7, 1, 0, 1, 1, 4, 0, 0);
      tick();

      // Top exponent saturates: 11 + 01 = 100, ex held at 7.
      present(0, 7, 3, 0, 6, 2);
      expect_out("ovf", 1, 4, 1, 0, 0, 0, 7, 1, 0);
      tick();

      // Zero A with a large exponent must not be chosen as base.
      present(0, 7, 0, 1, 2, 2);
      expect_out("a_zero", 1, 2, 0, 0, 1, 1, 3, 0, 0);
      tick();

      // Both zero.
      present(0, 5, 0, 0, 1, 0);
      expect_out("both_zero", 1, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();

      // Back-to-back pairs with a one-cycle stall on the third.
      set_ops(0, 3, 2, 0, 3, 2);          // p0 -> mxy1 100, ex 4
      bus.in_valid = 1'b1;
      tick();
      cmp("stall.t0.out_valid", 32'(bus.out_valid), 0);
      set_ops(0, 2, 3, 1, 4, 2);          // p1 -> mxy1 010, ex 5
      tick();
      expect_out("stall.t1", 1, 4, 1, 0, 0, 0, 4, 0, 0);
      set_ops(0, 7, 3, 0, 6, 2);          // p2, presented during hold: lost
      bus.hold = 1'b1;
      tick();
      expect_out("stall.t2", 1, 4, 1, 0, 0, 0, 4, 0, 0);
      bus.hold     = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      expect_out("stall.t3", 1, 2, 0, 0, 1, 1, 5, 0, 0);
      tick();
      cmp("stall.t4.out_valid", 32'(bus.out_valid), 0);
      tick();
      cmp("stall.t5.out_valid", 32'(bus.out_valid), 0);

      // Randomized traffic with stalls and occasional resets.
      for (int i = 0; i < 600; i++) begin
         set_ops(int'($urandom_range(0, 1)), int'($urandom_range(0, (1 << EW) - 1)),
                 int'($urandom_range(0, (1 << MW) - 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, (1 << EW) - 1)),
                 int'($urandom_range(0, (1 << MW) - 1)));
         bus.in_valid = ($urandom_range(0, 99) < 75);
         bus.hold     = ($urandom_range(0, 99) < 20);
         rst          = ($urandom_range(0, 99) < 2);
         tick();
      end
      rst          = 1'b0;
      bus.hold     = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_align_add
